mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction-fetch / data memory arbiter.
package mem_arb_pkg;

   localparam int unsigned MAX_WAIT_DEFAULT = 4;
   localparam int unsigned WAIT_CNT_W       = 4;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_D    = 2'd2
   } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous memory.
// Data has priority; fetch wins once it has lost MAX_WAIT consecutive cycles.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_WAIT   = MAX_WAIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_rsp_valid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_rsp_valid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_CNT = WAIT_CNT_W'(MAX_WAIT);

   grant_t                grant_c;
   grant_t                tag_q;
   logic [WAIT_CNT_W-1:0] if_wait_cnt_q;
   logic [WAIT_CNT_W-1:0] if_wait_cnt_d;

   // Grant decision; held off entirely while reset is asserted
   always_comb begin
      grant_c = GNT_NONE;
      if (!reset) begin
         if (if_req_valid && (!d_req_valid || (if_wait_cnt_q == MAX_WAIT_CNT))) begin
            grant_c = GNT_IF;
         end else if (d_req_valid) begin
            grant_c = GNT_D;
         end
      end
   end

   // Consecutive-loss counter for the fetch port, saturating at MAX_WAIT
   always_comb begin
      if_wait_cnt_d = if_wait_cnt_q;
      if (!if_req_valid || (grant_c == GNT_IF)) begin
         if_wait_cnt_d = '0;
      end else if (if_wait_cnt_q < MAX_WAIT_CNT) begin
         if_wait_cnt_d = if_wait_cnt_q + WAIT_CNT_W'(1);
      end
   end

   // Tag of the access in flight; selects which port sees the read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_q         <= GNT_NONE;
         if_wait_cnt_q <= '0;
      end else begin
         tag_q         <= grant_c;
         if_wait_cnt_q <= if_wait_cnt_d;
      end
   end

   assign if_req_ready = (grant_c == GNT_IF);
   assign d_req_ready  = (grant_c == GNT_D);

   assign mem_addr  = (grant_c == GNT_D) ? d_addr : if_addr;
   assign mem_we    = (grant_c == GNT_D) && d_we;
   assign mem_wdata = (grant_c == GNT_D) ? d_wdata : '0;

   assign if_rsp_valid = (tag_q == GNT_IF);
   assign d_rsp_valid  = (tag_q == GNT_D);
   assign if_rdata     = mem_rdata;
   assign d_rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic
// against a reference memory and a loss-count model of the priority rule.
module tb_mem_arbiter;

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 32;
   localparam int unsigned MW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

   typedef struct {
      bit            idle;
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct {
      bit            is_d;
      bit            is_write;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          if_req_valid;
   logic          if_req_ready;
   logic [AW-1:0] if_addr;
   logic          if_rsp_valid;
   logic [DW-1:0] if_rdata;
   logic          d_req_valid;
   logic          d_req_ready;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_rsp_valid;
   logic [DW-1:0] d_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   mem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_WAIT   (MW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_addr      (if_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rdata     (if_rdata),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rsp_valid  (d_rsp_valid),
      .d_rdata      (d_rdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port synchronous memory; reset reloads the 0x13 + address image
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (reset) begin
         for (int a = 0; a < int'(DEPTH); a++) mem[a] <= DW'(32'h13 + a);
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endfunction

   // Reference state
   logic [DW-1:0] ref_mem [DEPTH];
   exp_t          exp_q[$];
   int            model_loss = 0;
   bit            acc_if = 0, acc_d = 0;
   bit            if_pend = 0, d_pend = 0;
   logic [AW-1:0] if_pend_addr, d_pend_addr;
   logic          d_pend_we;
   logic [DW-1:0] d_pend_wdata;

   // Request-side checker: grant prediction, payload stability, expected responses
   always @(negedge clk) begin
      bit exp_if, exp_d;
      if (reset) begin
         chk("rst_if_ready",  32'(if_req_ready), 32'(0));
         chk("rst_d_ready",   32'(d_req_ready),  32'(0));
         chk("rst_mem_we",    32'(mem_we),       32'(0));
         chk("rst_if_rsp",    32'(if_rsp_valid), 32'(0));
         chk("rst_d_rsp",     32'(d_rsp_valid),  32'(0));
         for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = DW'(32'h13 + a);
         model_loss = 0;
         exp_q.delete();
         acc_if  = 0;
         acc_d   = 0;
         if_pend = 0;
         d_pend  = 0;
      end else begin
         exp_if = if_req_valid && (!d_req_valid || (model_loss == int'(MW)));
         exp_d  = d_req_valid && !exp_if;
         chk("if_ready", 32'(if_req_ready), 32'(exp_if));
         chk("d_ready",  32'(d_req_ready),  32'(exp_d));
         if (if_pend) begin
            chk("if_hold_valid", 32'(if_req_valid), 32'(1));
            chk("if_hold_addr",  32'(if_addr),      32'(if_pend_addr));
         end
         if (d_pend) begin
            chk("d_hold_valid", 32'(d_req_valid), 32'(1));
            chk("d_hold_addr",  32'(d_addr),      32'(d_pend_addr));
            chk("d_hold_we",    32'(d_we),        32'(d_pend_we));
            chk("d_hold_wdata", d_wdata,          d_pend_wdata);
         end
         if (exp_d) begin
            chk("mem_we_d",   32'(mem_we),   32'(d_we));
            chk("mem_addr_d", 32'(mem_addr), 32'(d_addr));
            if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
         end else begin
            chk("mem_we_idle", 32'(mem_we), 32'(0));
            if (exp_if) chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
         end
         if (if_req_valid && if_req_ready)
            exp_q.push_back('{is_d: 1'b0, is_write: 1'b0, data: ref_mem[if_addr], due: cyc + 1});
         if (d_req_valid && d_req_ready) begin
            if (d_we) begin
               ref_mem[d_addr] = d_wdata;
               exp_q.push_back('{is_d: 1'b1, is_write: 1'b1, data: '0, due: cyc + 1});
            end else begin
               exp_q.push_back('{is_d: 1'b1, is_write: 1'b0, data: ref_mem[d_addr], due: cyc + 1});
            end
         end
         if (!if_req_valid || exp_if) model_loss = 0;
         else if (model_loss < int'(MW)) model_loss++;
         if_pend      = if_req_valid && !if_req_ready;
         if_pend_addr = if_addr;
         d_pend       = d_req_valid && !d_req_ready;
         d_pend_addr  = d_addr;
         d_pend_we    = d_we;
         d_pend_wdata = d_wdata;
         acc_if       = if_req_valid && if_req_ready;
         acc_d        = d_req_valid && d_req_ready;
      end
   end

   // Response monitor: pops the scoreboard whenever a response is presented
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (if_rsp_valid || d_rsp_valid) begin
            chk("rsp_onehot", 32'(if_rsp_valid & d_rsp_valid), 32'(0));
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'({if_rsp_valid, d_rsp_valid}), 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk("rsp_cycle",   32'(cyc),          32'(e.due));
               chk("rsp_port_d",  32'(d_rsp_valid),  32'(e.is_d));
               chk("rsp_port_if", 32'(if_rsp_valid), 32'(!e.is_d));
               if (!e.is_write) begin
                  if (e.is_d) chk("d_rdata", d_rdata, e.data);
                  else        chk("if_rdata", if_rdata, e.data);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("rsp_missing", 32'({if_rsp_valid, d_rsp_valid}), e.is_d ? 32'(1) : 32'(2));
         end
      end
   end

   // Stimulus
   req_t if_q[$];
   req_t d_q[$];
   bit   rand_mode = 0;

   function automatic req_t mk(bit idle, int addr, bit we, logic [DW-1:0] wd);
      req_t r;
      r.idle  = idle;
      r.addr  = AW'(addr);
      r.we    = we;
      r.wdata = wd;
      return r;
   endfunction

   function automatic req_t rnd_req();
      return mk($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), $urandom);
   endfunction

   // Holds each request until accepted, then takes the next queue entry
   task automatic step(input logic rst_val);
      req_t r;
      @(posedge clk);
      #1;
      reset = rst_val;
      if (if_req_valid && acc_if) if_req_valid = 1'b0;
      if (!if_req_valid) begin
         if (rand_mode && if_q.size() == 0) if_q.push_back(rnd_req());
         if (if_q.size() > 0) begin
            r = if_q.pop_front();
            if (!r.idle) begin
               if_req_valid = 1'b1;
               if_addr      = r.addr;
            end
         end
      end
      if (d_req_valid && acc_d) d_req_valid = 1'b0;
      if (!d_req_valid) begin
         if (rand_mode && d_q.size() == 0) d_q.push_back(rnd_req());
         if (d_q.size() > 0) begin
            r = d_q.pop_front();
            if (!r.idle) begin
               d_req_valid = 1'b1;
               d_addr      = r.addr;
               d_we        = r.we;
               d_wdata     = r.wdata;
            end
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (if_q.size() > 0 || d_q.size() > 0 || if_req_valid || d_req_valid); i++)
         step(1'b0);
      repeat (3) step(1'b0);
   endtask

   initial begin
      reset        = 1'b1;
      if_req_valid = 1'b0;
      if_addr      = '0;
      d_req_valid  = 1'b0;
      d_we         = 1'b0;
      d_addr       = '0;
      d_wdata      = '0;
      repeat (3) step(1'b1);
      step(1'b0);

      // Back-to-back fetches from the preloaded image
      for (int a = 0; a < 3; a++) if_q.push_back(mk(0, a, 0, '0));
      drain();

      // Store then load of the same word
      d_q.push_back(mk(0, 5, 1, 32'hDEAD_BEEF));
      d_q.push_back(mk(0, 5, 0, '0));
      drain();

      // Sustained contention: data priority with periodic fetch override
      for (int i = 0; i < 6; i++)  if_q.push_back(mk(0, 100 + i, 0, '0));
      for (int i = 0; i < 20; i++) d_q.push_back(mk(0, 200 + i, i % 3 == 0, $urandom));
      drain();

      // Three losses, fetch wins alone, fetch idles a cycle, then data wins again
      if_q.push_back(mk(0, 300, 0, '0));
      if_q.push_back(mk(1, 0, 0, '0));
      if_q.push_back(mk(0, 301, 0, '0));
      for (int i = 0; i < 3; i++) d_q.push_back(mk(0, 400 + i, 0, '0));
      d_q.push_back(mk(1, 0, 0, '0));
      d_q.push_back(mk(1, 0, 0, '0));
      d_q.push_back(mk(0, 403, 0, '0));
      drain();

      // Reset right after a fetch is accepted discards its response
      if_q.push_back(mk(0, 7, 0, '0));
      step(1'b0);
      step(1'b1);
      d_q.push_back(mk(0, 5, 0, '0));
      step(1'b1);
      step(1'b1);
      step(1'b0);
      drain();

      // Randomized traffic
      rand_mode = 1;
      repeat (10000) step(1'b0);
      rand_mode = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
